led_pos_stepper: RTL

Position generator for the LED scanner; the counterpart of two_state_fsm, which consumes pos and produces dir.
- Consumes dir and advances a bounded position counter at a prescaled rate.
- Drives pos back to the FSM and a one-hot LED vector to the board.
- Closed loop with two_state_fsm gives the back-and-forth scan.

---
 rtl/led_pos_stepper_if.sv | 23 ++
 rtl/led_pos_stepper.sv | 103 ++++++++++
 2 files changed

// File: rtl/led_pos_stepper_if.sv
// Control and status bundle between the LED scan controller (master) and led_pos_stepper (slave).
interface led_pos_stepper_if #(
  parameter int unsigned WIDTH = 3
);
  logic                  en;
  logic                  clr;
  logic                  dir;
  logic [WIDTH-1:0]      pos;
  logic [2**WIDTH-1:0]   leds;
  logic                  step;
  logic                  at_edge;
  logic [7:0]            bounce_cnt;

  modport master (
    output en, clr, dir,
    input  pos, leds, step, at_edge, bounce_cnt
  );

  modport slave (
    input  en, clr, dir,
    output pos, leds, step, at_edge, bounce_cnt
  );
endinterface

// File: rtl/led_pos_stepper.sv
// Bounded, prescaled LED scan position counter with one-hot LED decode.
// Optional two-LED trail enabled by defining LED_POS_STEPPER_TRAIL_EN.
module led_pos_stepper #(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned PRESCALE = 4
) (
  input logic               clk,
  input logic               arst_n,
  led_pos_stepper_if.slave  bus
);

  localparam int unsigned NLED = 2 ** WIDTH;
  localparam int unsigned TW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}};
  localparam logic [TW-1:0]    TLAST = TW'(PRESCALE - 1);
  localparam logic [NLED-1:0]  LED0  = NLED'(1);

  logic [TW-1:0]    tick_q, tick_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic             step_q, step_d;
  logic [7:0]       bounce_q, bounce_d;
  logic             tick;

  always_comb begin
    tick     = bus.en && (tick_q == TLAST);
    tick_d   = tick_q;
    pos_d    = pos_q;
    step_d   = 1'b0;
    bounce_d = bounce_q;

    if (bus.en) begin
      tick_d = (tick_q == TLAST) ? '0 : tick_q + 1'b1;
    end

    // Saturate at both ends; a blocked tick is simply lost.
    if (tick) begin
      if (bus.dir && (pos_q != MAX)) begin
        pos_d  = pos_q + 1'b1;
        step_d = 1'b1;
      end else if (!bus.dir && (pos_q != '0)) begin
        pos_d  = pos_q - 1'b1;
        step_d = 1'b1;
      end
    end

    if (step_d && ((pos_d == '0) || (pos_d == MAX))) begin
      bounce_d = bounce_q + 8'd1;
    end

    if (bus.clr) begin
      tick_d   = '0;
      pos_d    = '0;
      step_d   = 1'b0;
      bounce_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tick_q   <= '0;
      pos_q    <= '0;
      step_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      tick_q   <= tick_d;
      pos_q    <= pos_d;
      step_q   <= step_d;
      bounce_q <= bounce_d;
    end
  end

`ifdef LED_POS_STEPPER_TRAIL_EN
  logic [WIDTH-1:0] prev_q, prev_d;

  always_comb begin
    prev_d = prev_q;
    if (step_d) begin
      prev_d = pos_q;
    end
    if (bus.clr) begin
      prev_d = '0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign bus.leds = (LED0 << pos_q) | (LED0 << prev_q);
`else
  assign bus.leds = LED0 << pos_q;
`endif

  assign bus.pos        = pos_q;
  assign bus.step       = step_q;
  assign bus.bounce_cnt = bounce_q;
  assign bus.at_edge    = (pos_q == '0) || (pos_q == MAX);

endmodule
